// File: rtl/bram_scan_ctrl.sv
// bram_scan_ctrl: scans a 256x16 block RAM and folds every word into a signature and a nonzero count.
// Optional FILL phase writing {k,~k} before the read pass is compiled in with BRAM_SCAN_FILL_EN.
module bram_scan_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int LAST_ADDR = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sig,
  output logic [ADDR_W:0]   nz_cnt
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

`ifdef BRAM_SCAN_FILL_EN
  typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, DRAIN, DONE} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              cap;

`ifdef BRAM_SCAN_FILL_EN
  logic [7:0] k8;
  assign k8 = 8'(addr);
`else
  assign ram_we    = 1'b0;
  assign ram_wdata = '0;
`endif

  // next-state, address stepping and RAM port drive
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    ram_addr  = '0;
    ram_re    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef BRAM_SCAN_FILL_EN
    ram_we    = 1'b0;
    ram_wdata = '0;
`endif
    unique case (state)
      IDLE: begin
        addr_nxt = '0;
        if (start) begin
`ifdef BRAM_SCAN_FILL_EN
          state_nxt = FILL;
`else
          state_nxt = READ;
`endif
        end
      end
`ifdef BRAM_SCAN_FILL_EN
      FILL: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = addr;
        ram_wdata = DATA_W'({k8, ~k8});
        if (addr == LAST) begin
          addr_nxt  = '0;
          state_nxt = READ;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
`endif
      READ: begin
        busy     = 1'b1;
        ram_re   = 1'b1;
        ram_addr = addr;
        if (addr == LAST) begin
          addr_nxt  = '0;
          state_nxt = DRAIN;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register, read-data capture and signature accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      cap    <= 1'b0;
      sig    <= '0;
      nz_cnt <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      cap   <= ram_re;
      if (state == IDLE && start) begin
        sig    <= '0;
        nz_cnt <= '0;
      end else if (cap) begin
        sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ ram_rdata;
        if (ram_rdata != '0)
          nz_cnt <= nz_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bram_scan_ctrl.sv
// tb_bram_scan_ctrl: randomized and directed scans against a RAM model and a reference signature.
// Build with BRAM_SCAN_FILL_EN to exercise the fill-then-read variant.
module tb_bram_scan_ctrl;

`ifdef BRAM_SCAN_FILL_EN
  localparam int DONE_LAT = 514;
  localparam int WE_EXP   = 256;
`else
  localparam int DONE_LAT = 258;
  localparam int WE_EXP   = 0;
`endif
  localparam int PERIOD = DONE_LAT + 1;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [7:0]  ram_addr;
  logic        ram_re, ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] rdata;
  logic        busy, done;
  logic [15:0] sig;
  logic [8:0]  nz_cnt;

  logic [15:0] mem [256];
  logic [15:0] pre [256];
  logic [15:0] exp_m [256];
  logic        load = 0;

  int pass = 0;
  int tot = 0;

  int done_at, busy_n, re_n, we_n, addr_err, data_err, extra_done;
  logic [15:0] sig_done;
  logic [8:0]  nz_done;
  logic [15:0] exp_s;
  int          exp_n;

  always #5 clk = ~clk;

  bram_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(rdata),
    .busy(busy), .done(done), .sig(sig), .nz_cnt(nz_cnt)
  );

  // RAM model: synchronous write and registered read, like SB_RAM40_4K
  always @(posedge clk) begin
    if (load) mem <= pre;
    else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) rdata <= mem[ram_addr];
    end
  end

  // reference: rotate-left-by-one then XOR, in plain integer arithmetic
  task automatic model();
    int t;
    t = 0;
    exp_n = 0;
    for (int i = 0; i < 256; i++) begin
      t = ((t * 2) % 65536) + (t / 32768);
      t = t ^ int'(exp_m[i]);
      if (exp_m[i] != 0) exp_n++;
    end
    exp_s = 16'(t);
  endtask

  // kind: 0 zero, 1 all-ones-lsb, 2 top word 8000, 3 word0 8000, else random
  task automatic load_mem(input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0: pre[i] = 16'h0000;
        1: pre[i] = 16'h0001;
        2: pre[i] = (i == 255) ? 16'h8000 : 16'h0000;
        3: pre[i] = (i == 0) ? 16'h8000 : 16'h0000;
        default: pre[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      endcase
`ifdef BRAM_SCAN_FILL_EN
      exp_m[i] = {8'(i), ~8'(i)};
`else
      exp_m[i] = pre[i];
`endif
    end
    @(negedge clk) load = 1;
    @(negedge clk) load = 0;
    model();
  endtask

  task automatic run_scan();
    int cyc;
    done_at = 0; busy_n = 0; re_n = 0; we_n = 0;
    addr_err = 0; data_err = 0; extra_done = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    cyc = 1;
    while (cyc <= DONE_LAT + 20) begin
      if (done) begin
        if (done_at == 0) begin
          done_at = cyc;
          sig_done = sig;
          nz_done = nz_cnt;
        end else extra_done++;
      end
      if (busy) busy_n++;
      if (ram_re) begin
        if (ram_addr !== 8'(re_n)) addr_err++;
        re_n++;
      end
      if (ram_we) begin
        if (ram_addr !== 8'(we_n) || ram_wdata !== {8'(we_n), ~8'(we_n)})
          data_err++;
        we_n++;
      end
      if (!ram_re && !ram_we && (ram_addr !== 0 || ram_wdata !== 0))
        addr_err++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 1;
    repeat (3) @(negedge clk);
    tot++;
    if ({busy, done, ram_re, ram_we} !== 4'b0) begin
      $display("FAIL reset_ctl: got %b want 0000", {busy, done, ram_re, ram_we});
    end else pass++;
    tot++;
    if (ram_addr !== 0 || ram_wdata !== 0 || sig !== 0 || nz_cnt !== 0) begin
      $display("FAIL reset_data: addr %h wdata %h sig %h nz %0d want 0",
               ram_addr, ram_wdata, sig, nz_cnt);
    end else pass++;
    rst = 0; start = 0;
    repeat (2) @(negedge clk);
    tot++;
    if (busy !== 1'b0) $display("FAIL reset_start_lost: busy %b want 0", busy);
    else pass++;
  endtask

  task automatic check_scan(input string nm);
    tot++;
    if (done_at !== DONE_LAT)
      $display("FAIL %s done_cycle: got %0d want %0d", nm, done_at, DONE_LAT);
    else pass++;
    tot++;
    if (busy_n !== DONE_LAT - 1 || extra_done !== 0)
      $display("FAIL %s busy/extra_done: got %0d/%0d want %0d/0",
               nm, busy_n, extra_done, DONE_LAT - 1);
    else pass++;
    tot++;
    if (re_n !== 256 || we_n !== WE_EXP)
      $display("FAIL %s re/we count: got %0d/%0d want 256/%0d",
               nm, re_n, we_n, WE_EXP);
    else pass++;
    tot++;
    if (addr_err !== 0 || data_err !== 0)
      $display("FAIL %s port_seq: addr_err %0d data_err %0d want 0/0",
               nm, addr_err, data_err);
    else pass++;
    tot++;
    if (sig_done !== exp_s || nz_done !== 9'(exp_n))
      $display("FAIL %s result: sig %h nz %0d want %h %0d",
               nm, sig_done, nz_done, exp_s, exp_n);
    else pass++;
    tot++;
    if (sig !== exp_s || nz_cnt !== 9'(exp_n))
      $display("FAIL %s hold: sig %h nz %0d want %h %0d",
               nm, sig, nz_cnt, exp_s, exp_n);
    else pass++;
  endtask

  task automatic test_patterns();
    string nm;
    for (int k = 0; k < 7; k++) begin
      load_mem(k);
      run_scan();
      nm = $sformatf("pat%0d", k);
      check_scan(nm);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int n_exp, w;
    logic bad;
    load_mem(6);
    bad = 0;
    @(negedge clk) start = 1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (done) begin
        q.push_back(c);
        if (busy || sig !== exp_s || nz_cnt !== 9'(exp_n)) bad = 1;
      end
    end
    start = 0;
    n_exp = 0;
    while (DONE_LAT + n_exp * PERIOD <= 600) n_exp++;
    tot++;
    if (q.size() !== n_exp)
      $display("FAIL b2b_count: got %0d want %0d", q.size(), n_exp);
    else pass++;
    for (int i = 0; i < q.size() && i < n_exp; i++) begin
      tot++;
      if (q[i] !== DONE_LAT + i * PERIOD)
        $display("FAIL b2b_done%0d: got %0d want %0d", i, q[i], DONE_LAT + i * PERIOD);
      else pass++;
    end
    tot++;
    if (bad) $display("FAIL b2b_result: got 1 want 0");
    else pass++;
    w = 0;
    while ((busy || done) && w < 2 * PERIOD) begin
      @(negedge clk);
      w++;
    end
    tot++;
    if (busy !== 1'b0) $display("FAIL b2b_drain: busy %b want 0", busy);
    else pass++;
  endtask

  task automatic test_abort();
    int dn;
    load_mem(6);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (99) @(negedge clk);
    rst = 1;
    @(negedge clk) rst = 0;
    tot++;
    if ({busy, done, ram_re, ram_we} !== 4'b0 || ram_addr !== 0 ||
        ram_wdata !== 0 || sig !== 0 || nz_cnt !== 0)
      $display("FAIL abort_idle: ctl %b addr %h sig %h nz %0d want 0",
               {busy, done, ram_re, ram_we}, ram_addr, sig, nz_cnt);
    else pass++;
    dn = 0;
    repeat (DONE_LAT + 50) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    tot++;
    if (dn !== 0) $display("FAIL abort_no_done: got %0d want 0", dn);
    else pass++;
    run_scan();
    check_scan("after_abort");
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule
